// File: rtl/lock_sim_pkg.sv
// Shared types and widths for the locked-adder key sweep controller.
package lock_sim_pkg;

    localparam int KEY_W = 64;
    localparam int OP_W  = 32;
    localparam int RES_W = 33;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_APPLY  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/lock_golden_check.sv
// Golden-sum register, result comparator and saturating mismatch counter
// for one sweep of the locked adder.
module lock_golden_check
    import lock_sim_pkg::*;
#(
    parameter int VEC_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 check_i,
    input  logic [OP_W-1:0]      add1_i,
    input  logic [OP_W-1:0]      add2_i,
    input  logic [RES_W-1:0]     result_i,
    input  logic [VEC_CNT_W-1:0] idx_i,
    output logic [RES_W-1:0]     golden_o,
    output logic                 mismatch_o,
    output logic [VEC_CNT_W-1:0] err_cnt_o,
    output logic [VEC_CNT_W-1:0] first_err_idx_o
);

    logic [RES_W-1:0]     golden_q;
    logic [VEC_CNT_W-1:0] err_cnt_q;
    logic [VEC_CNT_W-1:0] first_err_idx_q;

    assign mismatch_o      = check_i && (result_i != golden_q);
    assign golden_o        = golden_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = first_err_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            golden_q <= '0;
        end else if (load_i) begin
            golden_q <= RES_W'(add1_i) + RES_W'(add2_i);
        end
    end

    // err_cnt_q never returns to zero once it has counted, so zero means
    // "no mismatch yet in this sweep" even after saturation.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
        end else if (mismatch_o) begin
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + VEC_CNT_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_idx_q <= idx_i;
            end
        end
    end

endmodule

// File: rtl/lock_key_sweep_ctrl.sv
// Applies a candidate key and a stream of operand pairs to a locked adder,
// checks each result against a golden sum and reports the sweep outcome.
module lock_key_sweep_ctrl
    import lock_sim_pkg::*;
#(
    parameter int VEC_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [63:0]          key_i,
    input  logic [VEC_CNT_W-1:0] num_vec_i,
    input  logic                 vec_valid_i,
    output logic                 vec_ready_o,
    input  logic [31:0]          vec_add1_i,
    input  logic [31:0]          vec_add2_i,
    output logic [31:0]          dut_add1_o,
    output logic [31:0]          dut_add2_o,
    output logic [63:0]          dut_key_o,
    input  logic [32:0]          dut_result_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [VEC_CNT_W-1:0] err_cnt_o,
    output logic [VEC_CNT_W-1:0] first_err_idx_o,
    output logic [2:0]           state_o
);

    state_t state_q, state_d;

    logic [KEY_W-1:0]     key_q;
    logic [OP_W-1:0]      add1_q;
    logic [OP_W-1:0]      add2_q;
    logic [VEC_CNT_W-1:0] num_vec_q;
    logic [VEC_CNT_W-1:0] idx_q;
    logic                 pass_q;

    logic                 accept_start;
    logic                 vec_fire;
    logic                 last_vec;
    logic                 in_check;
    logic [RES_W-1:0]     golden;
    logic                 mismatch;
    logic [VEC_CNT_W-1:0] err_cnt;
    logic [VEC_CNT_W-1:0] first_err_idx;

    // Vector handshake: an operand pair transfers on a rising edge where
    // vec_valid_i && vec_ready_o; ready is high only in APPLY and does not
    // depend on valid; the source must hold the pair stable until it transfers.
    assign vec_ready_o  = (state_q == ST_APPLY);
    assign vec_fire     = vec_valid_i && vec_ready_o;
    assign accept_start = (state_q == ST_IDLE) && start_i;
    assign in_check     = (state_q == ST_CHECK);
    assign last_vec     = (idx_q == (num_vec_q - VEC_CNT_W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD;
            ST_LOAD:   state_d = (num_vec_q == '0) ? ST_DONE : ST_APPLY;
            ST_APPLY:  if (vec_valid_i) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK:  state_d = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q     <= '0;
            add1_q    <= '0;
            add2_q    <= '0;
            num_vec_q <= '0;
            idx_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (accept_start) begin
                key_q     <= key_i;
                num_vec_q <= num_vec_i;
                idx_q     <= '0;
                pass_q    <= 1'b0;
            end
            if (vec_fire) begin
                add1_q <= vec_add1_i;
                add2_q <= vec_add2_i;
            end
            if (in_check && !last_vec) begin
                idx_q <= idx_q + VEC_CNT_W'(1);
            end
            if (state_q == ST_DONE) begin
                pass_q <= (err_cnt == '0);
            end
        end
    end

    lock_golden_check #(
        .VEC_CNT_W(VEC_CNT_W)
    ) u_golden (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (accept_start),
        .load_i          (vec_fire),
        .check_i         (in_check),
        .add1_i          (vec_add1_i),
        .add2_i          (vec_add2_i),
        .result_i        (dut_result_i),
        .idx_i           (idx_q),
        .golden_o        (golden),
        .mismatch_o      (mismatch),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_err_idx)
    );

    // pass_o shows the verdict during the DONE pulse itself, then holds it.
    assign pass_o          = (state_q == ST_DONE) ? (err_cnt == '0) : pass_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);
    assign err_cnt_o       = err_cnt;
    assign first_err_idx_o = first_err_idx;
    assign dut_add1_o      = add1_q;
    assign dut_add2_o      = add2_q;
    assign dut_key_o       = key_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_lock_key_sweep_ctrl.sv
// Directed scoreboard bench for lock_key_sweep_ctrl with a behavioural
// adder model that can corrupt selected vectors.
module tb_lock_key_sweep_ctrl;
    import lock_sim_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [63:0]  key_i = '0;
    logic [W-1:0] num_vec_i = '0;
    logic         vec_valid_i = 1'b0;
    logic         vec_ready_o;
    logic [31:0]  vec_add1_i = '0;
    logic [31:0]  vec_add2_i = '0;
    logic [31:0]  dut_add1_o;
    logic [31:0]  dut_add2_o;
    logic [63:0]  dut_key_o;
    logic [32:0]  dut_result_i;
    logic         busy_o;
    logic         done_o;
    logic         pass_o;
    logic [W-1:0] err_cnt_o;
    logic [W-1:0] first_err_idx_o;
    logic [2:0]   state_o;

    lock_key_sweep_ctrl #(.VEC_CNT_W(W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .key_i           (key_i),
        .num_vec_i       (num_vec_i),
        .vec_valid_i     (vec_valid_i),
        .vec_ready_o     (vec_ready_o),
        .vec_add1_i      (vec_add1_i),
        .vec_add2_i      (vec_add2_i),
        .dut_add1_o      (dut_add1_o),
        .dut_add2_o      (dut_add2_o),
        .dut_key_o       (dut_key_o),
        .dut_result_i    (dut_result_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .err_cnt_o       (err_cnt_o),
        .first_err_idx_o (first_err_idx_o),
        .state_o         (state_o)
    );

    // clock / reset / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // adder model: correct sum, optionally corrupted on selected vector indices
    logic [3:0] fault_mask = 4'b0000;
    int         hs_cnt = 0;
    logic       fault_en;
    always @(posedge clk) begin
        if (start_i && !busy_o) hs_cnt <= 0;
        else if (vec_valid_i && vec_ready_o) hs_cnt <= hs_cnt + 1;
    end
    always_comb begin
        fault_en = 1'b0;
        if (hs_cnt >= 1 && hs_cnt <= 4) fault_en = fault_mask[hs_cnt-1];
    end
    assign dut_result_i = ({1'b0, dut_add1_o} + {1'b0, dut_add2_o}) ^ {32'd0, fault_en};

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [160:0] exp_vec_q[$];
    logic [48:0]  exp_done_q[$];
    logic [160:0] ev;
    logic [48:0]  ed;
    int           start_cyc = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // monitor: operands/key/golden on entering SETTLE, verdict on done pulse
    always @(negedge clk) begin
        if (!rst_i && state_o == ST_SETTLE) begin
            if (exp_vec_q.size() == 0) begin
                timeout_fail("vec_unexpected");
            end else begin
                ev = exp_vec_q.pop_front();
                chk("vec_apply", {dut_key_o, dut_add1_o, dut_add2_o, dut.u_golden.golden_o}, ev);
            end
        end
        if (!rst_i && done_o) begin
            if (exp_done_q.size() == 0) begin
                timeout_fail("done_unexpected");
            end else begin
                ed = exp_done_q.pop_front();
                chk("done_verdict", {16'(cyc - start_cyc), pass_o, err_cnt_o, first_err_idx_o}, ed);
            end
        end
    end

    // driver tasks
    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic start_sweep(input logic [63:0] k, input logic [W-1:0] n, input logic [15:0] lat,
                               input logic pass, input logic [W-1:0] err, input logic [W-1:0] first);
        exp_done_q.push_back({lat, pass, err, first});
        start_i = 1'b1;
        key_i = k;
        num_vec_i = n;
        @(posedge clk);
        #1 start_i = 1'b0;
        start_cyc = cyc - 1;
    endtask

    task automatic send_vec(input logic [63:0] k, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [32:0] golden);
        bit ok = 0;
        exp_vec_q.push_back({k, a1, a2, golden});
        vec_valid_i = 1'b1;
        vec_add1_i = a1;
        vec_add2_i = a2;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (state_o == ST_SETTLE) begin
                ok = 1;
                break;
            end
        end
        vec_valid_i = 1'b0;
        if (!ok) timeout_fail("vec_accept");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    localparam logic [63:0] K1 = 64'hA5A5_0F0F_1234_5678;
    localparam logic [63:0] K2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] K3 = 64'h0123_4567_89AB_CDEF;

    logic [63:0] snap_key;
    logic [31:0] snap_a1;
    logic [31:0] snap_a2;

    initial begin
        // reset state
        do_reset(3);
        chk("reset_outputs", {state_o, vec_ready_o, busy_o, done_o, pass_o, err_cnt_o, first_err_idx_o,
                              dut_add1_o, dut_add2_o, dut_key_o}, '0);

        // zero-vector sweep: done two cycles after start, passing
        start_sweep(K2, 16'd0, 16'd2, 1'b1, 16'd0, 16'd0);
        wait_idle();
        chk("n0_idle_hold", {pass_o, err_cnt_o, dut_key_o}, {1'b1, 16'd0, K2});

        // three correct vectors; a start pulse with another key mid-sweep is ignored
        fault_mask = 4'b0000;
        start_sweep(K1, 16'd3, 16'd11, 1'b1, 16'd0, 16'd0);
        send_vec(K1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        start_i = 1'b1;
        key_i = K3;
        send_vec(K1, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);
        start_i = 1'b0;
        send_vec(K1, 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789);
        wait_idle();
        chk("key_ignored_start", dut_key_o, K1);
        repeat (3) @(posedge clk);
        #1 chk("idle_hold_n3", {pass_o, err_cnt_o, dut_add1_o, dut_add2_o},
                {1'b1, 16'd0, 32'h1234_5678, 32'h1111_1111});

        // four vectors, adder wrong on indices 2 and 3, with a stall in APPLY
        fault_mask = 4'b1100;
        start_sweep(K3, 16'd4, 16'd19, 1'b0, 16'd2, 16'd2);
        send_vec(K3, 32'h0000_0001, 32'h0000_0002, 33'h0_0000_0003);
        repeat (2) @(posedge clk);
        #1 snap_key = dut_key_o;
        snap_a1 = dut_add1_o;
        snap_a2 = dut_add2_o;
        repeat (5) begin
            chk("stall_apply", {vec_ready_o, state_o, dut_key_o, dut_add1_o, dut_add2_o},
                {1'b1, ST_APPLY, snap_key, snap_a1, snap_a2});
            @(posedge clk);
            #1;
        end
        send_vec(K3, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
        send_vec(K3, 32'h0000_000A, 32'h0000_0005, 33'h0_0000_000F);
        send_vec(K3, 32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000);
        wait_idle();
        repeat (2) @(posedge clk);
        #1 chk("idle_hold_fail", {pass_o, err_cnt_o, first_err_idx_o}, {1'b0, 16'd2, 16'd2});
        fault_mask = 4'b0000;

        // reset while in CHECK, then a normal sweep
        start_i = 1'b1;
        key_i = K2;
        num_vec_i = 16'd2;
        @(posedge clk);
        #1 start_i = 1'b0;
        send_vec(K2, 32'h0000_0005, 32'h0000_0006, 33'h0_0000_000B);
        @(posedge clk);
        #1 chk("in_check", state_o, ST_CHECK);
        rst_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        start_i = 1'b0;
        chk("rst_mid_sweep", {state_o, vec_ready_o, busy_o, done_o, pass_o, err_cnt_o, first_err_idx_o,
                              dut_add1_o, dut_add2_o, dut_key_o}, '0);
        start_sweep(K1, 16'd1, 16'd5, 1'b1, 16'd0, 16'd0);
        send_vec(K1, 32'h0000_0007, 32'h0000_0008, 33'h0_0000_000F);
        wait_idle();

        repeat (2) @(posedge clk);
        #1 chk("vec_q_drained", 32'(exp_vec_q.size()), 0);
        chk("done_q_drained", 32'(exp_done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
